// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default format widths and the bit
// positions of the five IEEE exception flags used by the divider and its writeback.
package fp_pkg;

   localparam int FP_EXP    = 8;
   localparam int FP_FRAC   = 23;
   localparam int NUM_FLAGS = 5;

   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIVZERO   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Underflow and inexact are routine; only these three count as exceptions.
   function automatic logic is_exception(input logic [NUM_FLAGS-1:0] flags);
      return flags[FLAG_INVALID] | flags[FLAG_DIVZERO] | flags[FLAG_OVERFLOW];
   endfunction

endpackage

// File: rtl/fdiv_wb_fifo.sv
// First-word-fall-through FIFO holding packed {tag, flags, result} entries.
// The head entry is presented combinationally from the read pointer.
module fdiv_wb_fifo #(
   parameter int DATA_W = 41,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              do_push, do_pop;

   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr_reg];

   // Storage carries no reset; a flushed write is simply never read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
         if (do_push && !do_pop)      count_next = count_reg + 1'b1;
         else if (!do_push && do_pop) count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

endmodule

// File: rtl/fdiv_wb.sv
// Divider writeback: buffers tagged results, accumulates sticky fflags,
// counts exceptional results and raises an interrupt on newly-set enabled flags.
module fdiv_wb
   import fp_pkg::*;
#(
   parameter int EXP   = FP_EXP,
   parameter int FRAC  = FP_FRAC,
   parameter int WIDTH = EXP + FRAC + 1,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [4:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [4:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flush,
   input  logic             fflags_clr,
   input  logic [4:0]       flag_mask,
   output logic [4:0]       fflags,
   output logic [15:0]      exc_count,
   output logic             irq
);

   localparam int ENTRY_W = TAG_W + NUM_FLAGS + WIDTH;

   logic               push, pop, full, empty;
   logic [ENTRY_W-1:0] head;
   logic [4:0]         fflags_reg, fflags_next, fflags_eff, new_bits;
   logic [15:0]        exc_count_reg, exc_count_next;
   logic               irq_reg, irq_next;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   fdiv_wb_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data ({in_tag, in_flags, in_result}),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign {out_tag, out_flags, out_result} = head;

   // A clear in the same cycle means every incoming flag counts as new.
   assign fflags_eff = fflags_clr ? 5'b0 : fflags_reg;

   for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_new_bits
      assign new_bits[gi] = in_flags[gi] & flag_mask[gi] & ~fflags_eff[gi];
   end

   always_comb begin
      fflags_next    = fflags_eff | (push ? in_flags : 5'b0);
      irq_next       = push && (|new_bits);
      exc_count_next = exc_count_reg;
      if (push && is_exception(in_flags) && (exc_count_reg != 16'hFFFF)) begin
         exc_count_next = exc_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fflags_reg    <= '0;
         exc_count_reg <= '0;
         irq_reg       <= 1'b0;
      end else begin
         fflags_reg    <= fflags_next;
         exc_count_reg <= exc_count_next;
         irq_reg       <= irq_next;
      end
   end

   assign fflags    = fflags_reg;
   assign exc_count = exc_count_reg;
   assign irq       = irq_reg;

endmodule

// File: tb/tb_fdiv_wb.sv
// Scoreboard bench for fdiv_wb: the driver records accepted results in a queue
// and models fflags/exc_count/irq; a negedge monitor checks the DUT against them.
module tb_fdiv_wb;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_result, out_result;
   logic [4:0]  in_flags, out_flags, flag_mask, fflags;
   logic [3:0]  in_tag, out_tag;
   logic        flush, fflags_clr, irq;
   logic [15:0] exc_count;

   fdiv_wb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_flags   (in_flags),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .flush      (flush),
      .fflags_clr (fflags_clr),
      .flag_mask  (flag_mask),
      .fflags     (fflags),
      .exc_count  (exc_count),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   logic [40:0] exp_q[$];
   logic [4:0]  exp_fflags;
   logic [15:0] exp_exc;
   logic        exp_irq;
   int          size_pre = 0;
   bit          mon_en = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs to the model and retires the head on a pop.
   always @(negedge clk) begin
      size_pre = exp_q.size();
      if (mon_en) begin
         chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("fflags", 64'(fflags), 64'(exp_fflags));
         chk("exc_count", 64'(exc_count), 64'(exp_exc));
         chk("irq", 64'(irq), 64'(exp_irq));
         if (exp_q.size() != 0) begin
            chk("head", 64'({out_tag, out_flags, out_result}), 64'(exp_q[0]));
            if (rst_n && !flush && out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Reference behaviour for the coming edge, from the current inputs.
   task automatic model_update();
      logic       acc;
      logic [4:0] eff;
      if (!rst_n) begin
         exp_q.delete();
         exp_fflags = '0;
         exp_exc    = '0;
         exp_irq    = 1'b0;
      end else begin
         acc        = in_valid && (size_pre != DEPTH);
         eff        = fflags_clr ? 5'b0 : exp_fflags;
         exp_irq    = acc && ((in_flags & flag_mask & ~eff) != 5'b0);
         exp_fflags = eff | (acc ? in_flags : 5'b0);
         if (acc && (in_flags[4] || in_flags[3] || in_flags[2]) && exp_exc != 16'hFFFF)
            exp_exc = exp_exc + 16'd1;
         if (flush) exp_q.delete();
         else if (acc) exp_q.push_back({in_tag, in_flags, in_result});
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f,
                        input logic [3:0] t, input logic ordy, input logic fl,
                        input logic clr, input logic rn);
      in_valid   = v;
      in_result  = r;
      in_flags   = f;
      in_tag     = t;
      out_ready  = ordy;
      flush      = fl;
      fflags_clr = clr;
      rst_n      = rn;
      @(negedge clk);
      #1;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'b0, 4'h0, ordy, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [4:0] saved_ff;
      int         budget;
      flag_mask = 5'b0;
      drive(1'b0, 32'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b1;
      drive(1'b0, 32'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b1);

      // Single result, no flags
      drive(1'b1, 32'h3FC00000, 5'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_result", 64'(out_result), 64'h3FC00000);
      chk("t1_out_tag", 64'(out_tag), 64'd3);
      idle(2, 1'b1);

      // Fill to full, then a refused fifth push while popping
      for (int i = 0; i < 4; i++)
         drive(1'b1, 32'h40000000 + 32'(i), 5'b0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 32'hDEADBEEF, 5'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(5, 1'b1);

      // Divide-by-zero interrupt, then repeat with no new bit
      flag_mask = 5'b01000;
      drive(1'b1, 32'h7F800000, 5'b01000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t3_irq", 64'(irq), 64'd1);
      chk("t3_fflags", 64'(fflags), 64'h08);
      chk("t3_exc", 64'(exc_count), 64'd1);
      drive(1'b1, 32'h7F800000, 5'b01000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t3_irq2", 64'(irq), 64'd0);
      chk("t3_exc2", 64'(exc_count), 64'd2);
      idle(2, 1'b1);

      // Clear coinciding with a push keeps the new flags
      drive(1'b1, 32'h3F800001, 5'b00001, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t4_fflags", 64'(fflags), 64'h01);
      idle(2, 1'b1);

      // Flush with a push drops everything
      for (int i = 0; i < 3; i++)
         drive(1'b1, 32'h41000000 + 32'(i), 5'b0, 4'(i + 8), 1'b0, 1'b0, 1'b0, 1'b1);
      saved_ff = fflags;
      drive(1'b1, 32'h42000000, 5'b0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_fflags", 64'(fflags), 64'(saved_ff));
      idle(2, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic fl, v;
         flag_mask = 5'($urandom);
         fl = ($urandom_range(0, 31) == 0);
         v  = !fl && ($urandom_range(0, 3) != 0);
         drive(v, $urandom, 5'($urandom), 4'($urandom), 1'($urandom), fl,
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
      end
      idle(6, 1'b1);

      // Saturate the exception counter
      budget = 0;
      while (exp_exc != 16'hFFFF && budget < 70000) begin
         drive(1'b1, 32'h7F800000, 5'b00100, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
         budget++;
      end
      chk("t6_exc_preload", 64'(exc_count), 64'hFFFF);
      drive(1'b1, 32'h7F800000, 5'b00100, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_exc_sat", 64'(exc_count), 64'hFFFF);
      drive(1'b1, 32'h3F000000, 5'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
      chk("t6_rst_fflags", 64'(fflags), 64'd0);
      chk("t6_rst_exc", 64'(exc_count), 64'd0);
      chk("t6_rst_irq", 64'(irq), 64'd0);
      idle(3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fdiv_wb.md
# fdiv_wb

Result writeback stage sitting directly downstream of the combinational floating-point divider (`div`). It accepts the quotient `r` and the 5-bit exception `flags` with a valid/ready handshake. Results are buffered in a small first-word-fall-through FIFO tagged with the requester's ID. The stage also maintains the architectural sticky exception-flag register (fflags), a saturating exception counter and a maskable interrupt pulse.

## Interface
- `EXP`, 8, exponent width; must match the divider.
- `FRAC`, 23, fraction width; must match the divider.
- `WIDTH`, `EXP+FRAC+1`, result width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TAG_W`, 4, request tag width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  divider result valid.
- `in_ready`  out  1  stage can accept.
- `in_result`  in  WIDTH  divider `r`.
- `in_flags`  in  5  divider flags: [4] invalid, [3] div-by-0, [2] overflow, [1] underflow, [0] inexact.
- `in_tag`  in  TAG_W  request ID.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_result`  out  WIDTH  head result.
- `out_flags`  out  5  head flags.
- `out_tag`  out  TAG_W  head tag.
- `flush`  in  1  discard all buffered entries.
- `fflags_clr`  in  1  clear sticky flags.
- `flag_mask`  in  5  interrupt enable per flag bit.
- `fflags`  out  5  sticky accumulated flags.
- `exc_count`  out  16  count of accepted results with any of flags[4:2] set.
- `irq`  out  1  one-cycle interrupt pulse.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. A full FIFO does not accept, even in a cycle where it pops (no same-cycle bypass).
- `out_valid = (count != 0)`. `out_*` come from the storage entry at `rd_ptr` (FWFT). They are undefined-but-stable while `out_valid` = 0.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` is `$clog2(DEPTH+1)` bits.
- Simultaneous push and pop with `0 < count < DEPTH`: both pointers advance and `count` is unchanged.
- Precedence: reset > flush > push/pop.
  - `flush` zeroes the pointers and `count`.
  - A push in the same cycle as `flush` is dropped.
  - `flush` does not affect `fflags`, `exc_count` or `irq`.
- Sticky flags update at accept time, not at drain:
  - `fflags_next = (fflags_clr ? 0 : fflags) | (push ? in_flags : 0)`.
  - When clear and push coincide, the new flags survive.
- `exc_count` increments on a push with `|in_flags[4:2]` and saturates at 16'hFFFF. It is not affected by `fflags_clr`.
- `irq` is registered, high for one cycle after a push where `|(in_flags & flag_mask & ~fflags_eff)` and `fflags_eff = fflags_clr ? 0 : fflags`. The pulse fires only on newly-set, enabled bits.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `fflags` = 0.
  - `exc_count` = 0.
  - `irq` = 0.
  - Pointers and `count` = 0.
  - Storage contents are not reset.
- Latency: a push at edge N gives `out_valid` = 1 after edge N, with the data visible in cycle N+1. Throughput is 1 per cycle while not full.
- `fflags`, `exc_count` and `irq` update at the edge of the accepting push. `irq` is high during cycle N+1 only.
- `in_ready` depends only on registered `count` (no combinational path from `out_ready`).
- Reset asserted mid-stream discards all entries at that edge.

## Structure
- Shared package `fp_pkg` holds:
  - flag bit-position constants (`FLAG_INVALID`=4 … `FLAG_INEXACT`=0);
  - `EXP`/`FRAC` defaults.
- The divider's flag localparams migrate to `fp_pkg`.
- One sub-module, `fdiv_wb_fifo`: a parameterized FWFT FIFO of `{tag, flags, result}` providing push/pop/flush/count. The flag, counter and IRQ logic stays in `fdiv_wb`.

## Test plan
- Push 32'h3FC00000 with flags 5'b00000 and tag 3, `out_ready`=1 → `out_valid` in the next cycle with 32'h3FC00000, tag 3; `fflags` stays 0; no `irq`.
- `out_ready`=0, push 4 entries → `in_ready` drops after the 4th. A 5th `in_valid` asserted with `out_ready`=1 in the same cycle is not accepted. The entries drain in order with tags 0,1,2,3.
- `flag_mask`=5'b01000, push flags 5'b01000 (1.0/0 → 32'h7F800000):
  - `irq` pulses once, `fflags`=5'b01000, `exc_count`=1.
  - A second identical push → no `irq`, `exc_count`=2.
- `fflags_clr` in the same cycle as a push with flags 5'b00001 → `fflags`=5'b00001.
- Fill 3 entries, assert `flush` together with a push → `count`=0 and `out_valid`=0 next cycle; `fflags` unchanged.
- Preload `exc_count` to 16'hFFFF via 65535 overflow-flag pushes (`out_ready`=1), then push flags 5'b00100 → `exc_count` stays 16'hFFFF. A reset pulse then → all outputs at reset values.
